// File: rtl/score_controller.sv
// score_controller: game-state and scoring stage for the pong pipeline.
// Watches the ball x position on each frame tick, credits the player on the
// opposite side when the ball reaches a goal line, holds play for a serve
// delay between points, and reports scores, game-over and the winner.
module score_controller #(
  parameter int HOR_PIXELS  = 1024,
  parameter int BALL_SIZE   = 15,
  parameter int EDGE_MARGIN = 8,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start_btn,
  input  logic [10:0] x_ball,
  output logic        still_graphic,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        game_over,
  output logic        winner
);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  localparam logic [10:0] LEFT_LIMIT  = 11'(EDGE_MARGIN);
  localparam logic [10:0] RIGHT_LIMIT = 11'(HOR_PIXELS - BALL_SIZE - EDGE_MARGIN);
  localparam logic [3:0]  WIN_VALUE   = 4'(WIN_SCORE);
  localparam logic [7:0]  SERVE_LOAD  = 8'(SERVE_TICKS);

  state_t      state;
  logic [7:0]  serve_cnt;
  logic        start_prev;
  logic        start_rise;
  logic        left_goal;
  logic        right_goal;
  logic [3:0]  right_next;
  logic [3:0]  left_next;

  // Left-goal test wins if both ever held; they cannot for legal parameters.
  assign start_rise = start_btn & ~start_prev;
  assign left_goal  = (x_ball <= LEFT_LIMIT);
  assign right_goal = ~left_goal & (x_ball >= RIGHT_LIMIT);
  assign right_next = score_right + 4'd1;
  assign left_next  = score_left + 4'd1;

  // Remember the previous start level so a held button restarts only once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_prev <= 1'b0;
    else     start_prev <= start_btn;
  end

  // Game FSM with registered outputs: serve hold, goal detection, win check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      serve_cnt     <= 8'd0;
      still_graphic <= 1'b1;
      score_left    <= 4'd0;
      score_right   <= 4'd0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          still_graphic <= 1'b1;
          score_left    <= 4'd0;
          score_right   <= 4'd0;
          game_over     <= 1'b0;
          if (start_rise) begin
            serve_cnt <= SERVE_LOAD;
            state     <= SERVE;
          end
        end

        SERVE: begin
          if (timing_tick) begin
            serve_cnt <= serve_cnt - 8'd1;
            if (serve_cnt == 8'd1) begin
              still_graphic <= 1'b0;
              state         <= PLAY;
            end
          end
        end

        PLAY: begin
          if (timing_tick && (left_goal || right_goal)) begin
            // Freeze on the same edge as the score update.
            still_graphic <= 1'b1;
            if (left_goal) begin
              score_right <= right_next;
              if (right_next == WIN_VALUE) begin
                winner    <= 1'b1;
                game_over <= 1'b1;
                state     <= OVER;
              end else begin
                serve_cnt <= SERVE_LOAD;
                state     <= SERVE;
              end
            end else begin
              score_left <= left_next;
              if (left_next == WIN_VALUE) begin
                winner    <= 1'b0;
                game_over <= 1'b1;
                state     <= OVER;
              end else begin
                serve_cnt <= SERVE_LOAD;
                state     <= SERVE;
              end
            end
          end
        end

        OVER: begin
          still_graphic <= 1'b1;
          if (start_rise) begin
            score_left  <= 4'd0;
            score_right <= 4'd0;
            game_over   <= 1'b0;
            serve_cnt   <= SERVE_LOAD;
            state       <= SERVE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/score_controller.md
# score_controller

Game-state and scoring stage downstream of the ball controller. Watches `x_ball` on every `timing_tick`, detects when the ball crosses a side edge, credits the opposite player, and holds play between points. Drives `still_graphic` back to the ball controller, which freezes and recentres the ball while asserted. Exposes scores, game-over flag and winner to the drawing stages.

## Interface
Parameters:
- `HOR_PIXELS` — 1024 — visible horizontal resolution.
- `BALL_SIZE` — 15 — ball side length in pixels.
- `EDGE_MARGIN` — 8 — goal threshold distance from each screen edge.
- `WIN_SCORE` — 9 — points needed to win; legal range 1..15.
- `SERVE_TICKS` — 120 — `timing_tick`s the ball is held before each serve; legal range 1..255.

Ports:
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous, active-high reset.
- `timing_tick` in 1 — one-`clk` frame-rate strobe, shared with the ball controller.
- `start_btn` in 1 — start/restart request, already synchronised to `clk`, level.
- `x_ball` in 11 — ball left-edge x position from the ball controller.
- `still_graphic` out 1 — freeze/recentre request to the ball controller.
- `score_left` out 4 — left player score.
- `score_right` out 4 — right player score.
- `game_over` out 1 — high while in OVER.
- `winner` out 1 — 0 = left won, 1 = right won; valid while `game_over`.

## Operation
- FSM states: IDLE, SERVE, PLAY, OVER. All outputs are registered.
- Start edge: internal `start_prev` register. `start_rise = start_btn & ~start_prev`, evaluated on every `clk`, not gated by `timing_tick`.
- IDLE:
  - Outputs: `still_graphic`=1, scores 0, `game_over`=0.
  - On `start_rise`: load `serve_cnt` (8 bit) with `SERVE_TICKS`, go to SERVE.
- SERVE:
  - Output: `still_graphic`=1.
  - Each `timing_tick` decrements `serve_cnt`.
  - On a tick with `serve_cnt`==1: go to PLAY.
  - `start_rise` is ignored.
- PLAY:
  - Output: `still_graphic`=0.
  - On each `timing_tick`, test the goal conditions below; with no tick, nothing changes.
  - Left goal: `x_ball <= EDGE_MARGIN`. Credits `score_right`.
  - Right goal: `x_ball >= HOR_PIXELS-BALL_SIZE-EDGE_MARGIN`. Credits `score_left`.
  - The left-goal test has priority; both cannot hold for legal parameters.
  - After a goal, if the incremented score equals `WIN_SCORE`: go to OVER and set `winner` (right goal → `winner`=0, left goal → `winner`=1).
  - After a goal otherwise: reload `serve_cnt`, go to SERVE.
  - `start_rise` is ignored.
- OVER:
  - Outputs: `still_graphic`=1, `game_over`=1; scores and `winner` are held.
  - On `start_rise`: clear both scores and `game_over`, reload `serve_cnt`, go to SERVE.
- Only one goal can be credited per point. The SERVE hold covers the ball controller's own recentre, so a ball lingering at an edge cannot double-count.
- Score arithmetic is 4-bit unsigned. It never wraps, because the winning increment exits to OVER.

## Timing
- Reset (async assert, synchronous deassert on `clk` edge):
  - State IDLE.
  - `still_graphic`=1, `score_left`=0, `score_right`=0, `game_over`=0, `winner`=0.
  - `serve_cnt`=0, `start_prev`=0.
- Goal latency: a goal sampled on the `clk` edge where `timing_tick`=1 updates the score and sets `still_graphic`=1 on that same edge, so both are visible the next cycle. The ball controller therefore sees the freeze within one `clk` of its own recentre.
- SERVE length: exactly `SERVE_TICKS` ticks. `still_graphic` falls on the edge that consumes the last tick.
- IDLE/OVER → SERVE: takes one `clk` after the `start_btn` rising level is sampled.
- A held `start_btn` produces one `start_rise` only.
- `rst` asserted mid-PLAY or mid-SERVE: everything returns immediately (asynchronously) to the reset values above.

## Test plan
- Reset, then start, with `SERVE_TICKS`=3: assert `start_btn` one cycle, give 3 ticks → `still_graphic` 1 through the 3rd tick edge, then 0; state PLAY.
- In PLAY, `x_ball`=8 on a tick → `score_right`=1, `score_left`=0, `still_graphic`=1 next cycle. `x_ball`=9 on a tick → no change.
- In PLAY, `x_ball`=1001 (1024-15-8) on a tick → `score_left`=1. `x_ball`=1000 → no change. `x_ball`=8 with `timing_tick`=0 → no change.
- `WIN_SCORE`=3: three right-goal points → `score_left`=3, `game_over`=1, `winner`=0. Further ticks with `x_ball`=1001 → scores frozen.
- In OVER, hold `start_btn` high for 10 cycles → single restart: scores 0, `game_over`=0, SERVE. A second press during SERVE → ignored.
- `rst` pulse mid-SERVE with `score_left`=2 → all outputs at reset values before the next `clk` edge; state IDLE.
